// File: rtl/fetch_stage_pkg.sv
// Shared constants, next-PC select encodings and FSM state type for the fetch stage.
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  localparam logic [1:0] PC_SEQ  = 2'b00;
  localparam logic [1:0] PC_BR   = 2'b01;
  localparam logic [1:0] PC_JALR = 2'b10;

  typedef enum logic [1:0] {
    ST_FETCH     = 2'b00,
    ST_WAIT      = 2'b01,
    ST_WAIT_DROP = 2'b10
  } fetch_state_e;

  // Instruction addresses are always word aligned.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register with reset > flush > bubble > stall > load priority.
module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_flush,
  input  logic        i_bubble,
  input  logic        i_stall,
  input  logic        i_load,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4,
  output logic        o_valid
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        valid_q, valid_d;

  always_comb begin
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    // With no stall, a cycle without a deliverable instruction becomes a bubble.
    if (i_flush || i_bubble || (!i_stall && !i_load)) begin
      instr_d    = NOP_INSTR;
      pc_d       = 32'h0;
      pc_plus4_d = 32'h0;
      valid_d    = 1'b0;
    end else if (!i_stall) begin
      instr_d    = i_instr;
      pc_d       = i_pc;
      pc_plus4_d = i_pc + 32'd4;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      instr_q    <= NOP_INSTR;
      pc_q       <= 32'h0;
      pc_plus4_q <= 32'h0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign o_instr    = instr_q;
  assign o_pc       = pc_q;
  assign o_pc_plus4 = pc_plus4_q;
  assign o_valid    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, fetch-miss FSM, redirect handling and IF/ID register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = fetch_stage_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_pc_src_e,
  input  logic [31:0] i_pc_target_e,
  input  logic [31:0] i_alu_result_e,
  input  logic        i_pc_stall,
  input  logic        i_if_id_stall,
  input  logic        i_if_id_flush,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_imem_valid,
  output logic [31:0] o_instr_d,
  output logic [31:0] o_pc_d,
  output logic [31:0] o_pc_plus4_d,
  output logic        o_valid_d,
  output logic        o_fetch_busy
);
  import fetch_stage_pkg::*;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  redirect_pc_q, redirect_pc_d;

  logic         redirect;
  logic [31:0]  redirect_tgt;
  logic         load_en;

  assign redirect     = (i_pc_src_e == PC_BR) || (i_pc_src_e == PC_JALR);
  assign redirect_tgt = align_word((i_pc_src_e == PC_BR) ? i_pc_target_e : i_alu_result_e);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    redirect_pc_d = redirect_pc_q;
    load_en       = 1'b0;
    unique case (state_q)
      ST_FETCH, ST_WAIT: begin
        if (redirect) begin
          // An outstanding miss must keep its address until answered, so park the target.
          if (i_imem_valid || (state_q == ST_FETCH)) begin
            pc_d    = redirect_tgt;
            state_d = ST_FETCH;
          end else begin
            redirect_pc_d = redirect_tgt;
            state_d       = ST_WAIT_DROP;
          end
        end else if (i_imem_valid) begin
          load_en = 1'b1;
          if (!i_pc_stall) begin
            pc_d = pc_q + 32'd4;
          end
          state_d = ST_FETCH;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT_DROP: begin
        if (i_imem_valid) begin
          pc_d    = redirect ? redirect_tgt : redirect_pc_q;
          state_d = ST_FETCH;
        end else if (redirect) begin
          redirect_pc_d = redirect_tgt;
        end
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= ST_FETCH;
      pc_q          <= RESET_PC;
      redirect_pc_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign o_imem_req   = 1'b1;
  assign o_imem_addr  = pc_q;
  assign o_fetch_busy = (state_q != ST_FETCH);

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_flush    (i_if_id_flush),
    .i_bubble   (redirect),
    .i_stall    (i_if_id_stall),
    .i_load     (load_en),
    .i_instr    (i_imem_rdata),
    .i_pc       (pc_q),
    .o_instr    (o_instr_d),
    .o_pc       (o_pc_d),
    .o_pc_plus4 (o_pc_plus4_d),
    .o_valid    (o_valid_d)
  );

endmodule
